instr_fetch_reg: RTL and testbench

// Fetch stage of the multicycle MIPS core, directly upstream of the control FSM. Holds the PC, issues

---
 rtl/instr_fetch_reg.sv | 117 +++++++++++
 tb/tb_instr_fetch_reg.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_reg.sv
// Fetch stage of the multicycle MIPS core. Holds the PC, issues one
// instruction-memory read per fetch request, latches the instruction
// register and splits it into the fields the control FSM decodes.
module instr_fetch_reg #(
   parameter int            AW       = 32,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          IRWE,
   input  logic          PC_write,
   input  logic          branch,
   input  logic          zero,
   input  logic [1:0]    PCSel,
   input  logic [31:0]   alu_result,
   input  logic [31:0]   alu_out,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic [31:0]   imem_rdata,
   input  logic          imem_ack,
   output logic          fetch_stall,
   output logic          ir_valid,
   output logic [AW-1:0] pc,
   output logic [5:0]    Op,
   output logic [5:0]    func,
   output logic [4:0]    rs,
   output logic [4:0]    rt,
   output logic [4:0]    rd,
   output logic [31:0]   imm_se
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } fetch_state_e;

   fetch_state_e  state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [AW-1:0] req_addr_q, req_addr_d;
   logic [31:0]   ir_q, ir_d;
   logic          ir_valid_q, ir_valid_d;
   logic          pc_en;

   // Next PC: loaded on an unconditional write or a taken branch, otherwise held.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      pc_d  = pc_q;
      pc_en = PC_write | (branch & zero);
      if (pc_en) begin
         unique case (PCSel)
            2'b00:   pc_d = alu_result[AW-1:0];
            2'b01:   pc_d = alu_out[AW-1:0];
            // Jump keeps the upper bits of the already-incremented PC.
            2'b10:   pc_d = {pc_q[AW-1:26], ir_q[25:0]};
            default: pc_d = pc_q;
         endcase
      end
   end

   // Fetch FSM next state: capture the pre-update PC on request, load IR on ack.
   always_comb begin
      state_d    = state_q;
      req_addr_d = req_addr_q;
      ir_d       = ir_q;
      ir_valid_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (IRWE) begin
               req_addr_d = pc_q;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            // A repeated IRWE here is ignored; only the ack moves the FSM.
            if (imem_ack) begin
               ir_d       = imem_rdata;
               ir_valid_d = 1'b1;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers with synchronous reset; reset overrides a coincident ack.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      if (RST) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         req_addr_q <= '0;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
      end
   end

   assign imem_req    = (state_q == S_WAIT);
   assign imem_addr   = req_addr_q;
   assign fetch_stall = (state_q == S_WAIT);
   assign ir_valid    = ir_valid_q;
   assign pc          = pc_q;

   // Decode fields are pure wiring from IR, so they stay stable between fetches.
   assign Op     = ir_q[31:26];
   assign rs     = ir_q[25:21];
   assign rt     = ir_q[20:16];
   assign rd     = ir_q[15:11];
   assign func   = ir_q[5:0];
   assign imm_se = {{16{ir_q[15]}}, ir_q[15:0]};

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Directed bench for instr_fetch_reg: reset, fetch latency, branch/jump PC
// update, reset during an outstanding fetch and IRWE ignored while waiting.
module tb_instr_fetch_reg;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        IRWE = 1'b0;
   logic        PC_write = 1'b0;
   logic        branch = 1'b0;
   logic        zero = 1'b0;
   logic [1:0]  PCSel = 2'b00;
   logic [31:0] alu_result = '0;
   logic [31:0] alu_out = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        imem_ack = 1'b0;
   logic        fetch_stall;
   logic        ir_valid;
   logic [31:0] pc;
   logic [5:0]  Op, func;
   logic [4:0]  rs, rt, rd;
   logic [31:0] imm_se;

   int checks = 0;
   int errors = 0;

   instr_fetch_reg #(.AW(32), .RESET_PC(32'h0)) dut (
      .CLK(CLK), .RST(RST), .IRWE(IRWE), .PC_write(PC_write), .branch(branch),
      .zero(zero), .PCSel(PCSel), .alu_result(alu_result), .alu_out(alu_out),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .imem_ack(imem_ack), .fetch_stall(fetch_stall), .ir_valid(ir_valid),
      .pc(pc), .Op(Op), .func(func), .rs(rs), .rt(rt), .rd(rd), .imm_se(imm_se)
   );

   always #5 CLK = ~CLK;

   // One rising edge, then settle; inputs are changed and outputs sampled here.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic load_pc(input logic [31:0] val);
      PC_write = 1'b1; PCSel = 2'b00; alu_result = val;
      step();
      PC_write = 1'b0;
   endtask

   task automatic do_fetch(input logic [31:0] data);
      IRWE = 1'b1;
      step();
      IRWE = 1'b0; imem_ack = 1'b1; imem_rdata = data;
      step();
      imem_ack = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      step();
      RST = 1'b0;
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
      checks++; if (Op !== 6'h0) begin errors++; $display("FAIL reset_op: got %h expected %h", Op, 6'h0); end
      checks++; if (func !== 6'h0) begin errors++; $display("FAIL reset_func: got %h expected %h", func, 6'h0); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
      checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", fetch_stall); end
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_irvalid: got %b expected 0", ir_valid); end
      // Stray ack while idle must not load IR.
      imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
      step();
      imem_ack = 1'b0;
      checks++; if (Op !== 6'h0) begin errors++; $display("FAIL idle_ack_op: got %h expected 0", Op); end
      checks++; if (func !== 6'h0) begin errors++; $display("FAIL idle_ack_func: got %h expected 0", func); end
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL idle_ack_irvalid: got %b expected 0", ir_valid); end
      checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL idle_ack_stall: got %b expected 0", fetch_stall); end
   endtask

   task automatic test_fetch();
      IRWE = 1'b1; PC_write = 1'b1; PCSel = 2'b00; alu_result = 32'h1;
      step();
      IRWE = 1'b0; PC_write = 1'b0;
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL fetch_req: got %b expected 1", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL fetch_addr: got %h expected 0", imem_addr); end
      checks++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL fetch_stall1: got %b expected 1", fetch_stall); end
      checks++; if (pc !== 32'h1) begin errors++; $display("FAIL fetch_pc: got %h expected 1", pc); end
      step();
      checks++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL fetch_stall2: got %b expected 1", fetch_stall); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL fetch_addr_held: got %h expected 0", imem_addr); end
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL fetch_early_irvalid: got %b expected 0", ir_valid); end
      imem_ack = 1'b1; imem_rdata = 32'h8C22_0004;
      step();
      imem_ack = 1'b0;
      checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL fetch_irvalid: got %b expected 1", ir_valid); end
      checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL fetch_stall_end: got %b expected 0", fetch_stall); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL fetch_req_end: got %b expected 0", imem_req); end
      checks++; if (Op !== 6'h23) begin errors++; $display("FAIL fetch_op: got %h expected 23", Op); end
      checks++; if (rs !== 5'd1) begin errors++; $display("FAIL fetch_rs: got %h expected 1", rs); end
      checks++; if (rt !== 5'd2) begin errors++; $display("FAIL fetch_rt: got %h expected 2", rt); end
      checks++; if (imm_se !== 32'h4) begin errors++; $display("FAIL fetch_imm: got %h expected 4", imm_se); end
      checks++; if (func !== 6'h04) begin errors++; $display("FAIL fetch_func: got %h expected 04", func); end
      checks++; if (pc !== 32'h1) begin errors++; $display("FAIL fetch_pc_after: got %h expected 1", pc); end
      step();
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL fetch_irvalid_pulse: got %b expected 0", ir_valid); end
      checks++; if (Op !== 6'h23) begin errors++; $display("FAIL fetch_ir_hold: got %h expected 23", Op); end
   endtask

   task automatic test_branch();
      load_pc(32'h5);
      checks++; if (pc !== 32'h5) begin errors++; $display("FAIL branch_setup_pc: got %h expected 5", pc); end
      branch = 1'b1; zero = 1'b0; PCSel = 2'b01; alu_out = 32'h20;
      step();
      checks++; if (pc !== 32'h5) begin errors++; $display("FAIL branch_not_taken: got %h expected 5", pc); end
      zero = 1'b1;
      step();
      branch = 1'b0; zero = 1'b0;
      checks++; if (pc !== 32'h20) begin errors++; $display("FAIL branch_taken: got %h expected 20", pc); end
      PCSel = 2'b00; alu_result = 32'h99;
      step();
      checks++; if (pc !== 32'h20) begin errors++; $display("FAIL pc_hold_no_en: got %h expected 20", pc); end
      PC_write = 1'b1; PCSel = 2'b11;
      step();
      PC_write = 1'b0;
      checks++; if (pc !== 32'h20) begin errors++; $display("FAIL pc_hold_sel11: got %h expected 20", pc); end
   endtask

   task automatic test_jump();
      do_fetch(32'h0800_0100);
      load_pc(32'h0400_0010);
      checks++; if (Op !== 6'h02) begin errors++; $display("FAIL jump_op: got %h expected 02", Op); end
      PC_write = 1'b1; PCSel = 2'b10;
      step();
      PC_write = 1'b0;
      checks++; if (pc !== 32'h0400_0100) begin errors++; $display("FAIL jump_pc: got %h expected 04000100", pc); end
   endtask

   task automatic test_reset_mid_fetch();
      // Reset alone during WAIT, then a late ack.
      IRWE = 1'b1;
      step();
      IRWE = 1'b0;
      checks++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL rmf_stall: got %b expected 1", fetch_stall); end
      RST = 1'b1;
      step();
      RST = 1'b0;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rmf_req: got %b expected 0", imem_req); end
      checks++; if (Op !== 6'h0) begin errors++; $display("FAIL rmf_op: got %h expected 0", Op); end
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rmf_pc: got %h expected 0", pc); end
      imem_ack = 1'b1; imem_rdata = 32'h8C22_0004;
      step();
      imem_ack = 1'b0;
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL rmf_late_irvalid: got %b expected 0", ir_valid); end
      checks++; if (Op !== 6'h0) begin errors++; $display("FAIL rmf_late_op: got %h expected 0", Op); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rmf_late_req: got %b expected 0", imem_req); end
      // Reset and ack in the same cycle: reset wins.
      do_fetch(32'h0800_0100);
      IRWE = 1'b1;
      step();
      IRWE = 1'b0; RST = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h8C22_0004;
      step();
      RST = 1'b0; imem_ack = 1'b0;
      checks++; if (Op !== 6'h0) begin errors++; $display("FAIL rst_ack_op: got %h expected 0", Op); end
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL rst_ack_irvalid: got %b expected 0", ir_valid); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_ack_req: got %b expected 0", imem_req); end
      step();
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL rst_ack_irvalid2: got %b expected 0", ir_valid); end
   endtask

   task automatic test_back_to_back();
      load_pc(32'h10);
      IRWE = 1'b1;
      step();
      checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL b2b_addr: got %h expected 10", imem_addr); end
      PC_write = 1'b1; PCSel = 2'b00; alu_result = 32'h30;
      step();
      PC_write = 1'b0;
      checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL b2b_addr_held: got %h expected 10", imem_addr); end
      checks++; if (pc !== 32'h30) begin errors++; $display("FAIL b2b_pc: got %h expected 30", pc); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL b2b_req: got %b expected 1", imem_req); end
      imem_ack = 1'b1; imem_rdata = 32'hAC43_FFF8;
      step();
      IRWE = 1'b0; imem_ack = 1'b0;
      checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL b2b_irvalid: got %b expected 1", ir_valid); end
      checks++; if (Op !== 6'h2B) begin errors++; $display("FAIL b2b_op: got %h expected 2b", Op); end
      checks++; if (rs !== 5'd2) begin errors++; $display("FAIL b2b_rs: got %h expected 2", rs); end
      checks++; if (rt !== 5'd3) begin errors++; $display("FAIL b2b_rt: got %h expected 3", rt); end
      checks++; if (imm_se !== 32'hFFFF_FFF8) begin errors++; $display("FAIL b2b_imm: got %h expected fffffff8", imm_se); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL b2b_req_end: got %b expected 0", imem_req); end
      step();
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL b2b_single_pulse: got %b expected 0", ir_valid); end
      imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
      step();
      imem_ack = 1'b0;
      checks++; if (Op !== 6'h2B) begin errors++; $display("FAIL b2b_no_reload: got %h expected 2b", Op); end
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_irvalid: got %b expected 0", ir_valid); end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_branch();
      test_jump();
      test_reset_mid_fetch();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
